// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator floor controller: floor count, the
// "no request" code shown on the requested-floor display, FSM state encoding,
// the status-flag payload and a lowest-pending-floor helper.
package elevator_pkg;

    localparam int unsigned NUM_FLOORS = 4;
    localparam int unsigned FLOOR_W    = 2;
    localparam int unsigned REQ_W      = 3;
    localparam int unsigned STATE_W    = 2;

    localparam logic [REQ_W-1:0] NO_REQ = 3'b111;

    localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [STATE_W-1:0] ST_MOVE_UP = 2'd1;
    localparam logic [STATE_W-1:0] ST_MOVE_DN = 2'd2;
    localparam logic [STATE_W-1:0] ST_DOOR    = 2'd3;

    // One-hot cabin status, all zero when idle.
    typedef struct packed {
        logic moving_up;
        logic moving_dn;
        logic door_open;
    } status_t;

    // Lowest set index of a request mask (0 when the mask is empty).
    function automatic logic [FLOOR_W-1:0] lowest_floor(input logic [NUM_FLOORS-1:0] mask);
        logic [FLOOR_W-1:0] idx;
        idx = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (mask[i]) idx = FLOOR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/elevator_floor_ctrl_tick_counter.sv
// Modulo-N cycle timer used for travel, door and display timing.
// Ports: clk, reset (sync, active-high), clear (restart from 0),
//        en (count this cycle), done (last count of the period while enabled).
module tick_counter #(
    parameter int unsigned N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic done
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] cnt;

    // Count 0..N-1 and wrap; clear has priority over counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    // A clear in the same cycle suppresses the period end (door restart).
    assign done = en && !clear && (cnt == LAST);

endmodule

// File: rtl/elevator_floor_ctrl.sv
// Four-floor elevator controller. Latches floor calls into a request mask,
// serves the lowest pending floor per idle decision, steps the cabin one floor
// per travel period, holds the door for a door period, and alternates the
// display mux between current and requested floor while a target is active.
// Ports: clk, reset (sync, active-high), btn[3:0] floor calls,
//        cur_floor, req_floor (3'b111 = none), sel (display mux select),
//        moving_up / moving_dn / door_open one-hot status flags.
module elevator_floor_ctrl
    import elevator_pkg::*;
#(
    parameter int unsigned TRAVEL_TICKS = 50_000_000,
    parameter int unsigned DOOR_TICKS   = 100_000_000,
    parameter int unsigned DISP_TICKS   = 25_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] btn,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic [REQ_W-1:0]      req_floor,
    output logic                  sel,
    output logic                  moving_up,
    output logic                  moving_dn,
    output logic                  door_open
);

    logic [STATE_W-1:0]    state, state_nxt;
    logic [FLOOR_W-1:0]    cur_floor_nxt;
    logic [REQ_W-1:0]      req_floor_nxt;
    logic [NUM_FLOORS-1:0] req_mask, req_mask_nxt;
    logic                  sel_nxt;
    status_t               status_nxt;

    logic [NUM_FLOORS-1:0] serve;
    logic [NUM_FLOORS-1:0] block;
    logic [FLOOR_W-1:0]    target;
    logic [FLOOR_W-1:0]    next_target;

    logic travel_en, travel_done;
    logic door_en, door_restart, door_done;
    logic disp_en, disp_load, disp_done;

    assign target       = req_floor[FLOOR_W-1:0];
    assign travel_en    = (state == ST_MOVE_UP) || (state == ST_MOVE_DN);
    assign door_en      = (state == ST_DOOR);
    assign door_restart = door_en && btn[cur_floor];
    assign disp_load    = (state == ST_IDLE) && (req_mask != '0);
    assign disp_en      = (req_floor != NO_REQ);

    tick_counter #(.N(TRAVEL_TICKS)) u_travel (
        .clk   (clk),
        .reset (reset),
        .clear (!travel_en),
        .en    (travel_en),
        .done  (travel_done)
    );

    tick_counter #(.N(DOOR_TICKS)) u_door (
        .clk   (clk),
        .reset (reset),
        .clear (!door_en || door_restart),
        .en    (door_en),
        .done  (door_done)
    );

    tick_counter #(.N(DISP_TICKS)) u_disp (
        .clk   (clk),
        .reset (reset),
        .clear (disp_load || !disp_en),
        .en    (disp_en),
        .done  (disp_done)
    );

    // Next-state, target, floor, mask and display decisions.
    always_comb begin
        state_nxt     = state;
        cur_floor_nxt = cur_floor;
        req_floor_nxt = req_floor;
        sel_nxt       = sel;
        serve         = '0;
        block         = '0;
        next_target   = lowest_floor(req_mask);
        status_nxt    = '0;

        // The floor whose door is open does not re-register its own call.
        if (state == ST_DOOR) block[cur_floor] = 1'b1;

        case (state)
            ST_IDLE: begin
                if (req_mask != '0) begin
                    req_floor_nxt = {1'b0, next_target};
                    if (next_target > cur_floor) begin
                        state_nxt = ST_MOVE_UP;
                    end else if (next_target < cur_floor) begin
                        state_nxt = ST_MOVE_DN;
                    end else begin
                        state_nxt          = ST_DOOR;
                        serve[next_target] = 1'b1;
                    end
                end
            end
            ST_MOVE_UP: begin
                if (travel_done && (cur_floor != FLOOR_W'(NUM_FLOORS - 1))) begin
                    cur_floor_nxt = cur_floor + FLOOR_W'(1);
                    if (cur_floor_nxt == target) begin
                        state_nxt     = ST_DOOR;
                        serve[target] = 1'b1;
                    end
                end
            end
            ST_MOVE_DN: begin
                if (travel_done && (cur_floor != '0)) begin
                    cur_floor_nxt = cur_floor - FLOOR_W'(1);
                    if (cur_floor_nxt == target) begin
                        state_nxt     = ST_DOOR;
                        serve[target] = 1'b1;
                    end
                end
            end
            default: begin
                if (door_done) begin
                    state_nxt     = ST_IDLE;
                    req_floor_nxt = NO_REQ;
                end
            end
        endcase

        // Serving a floor wins over a same-cycle call for that floor.
        req_mask_nxt = (req_mask | (btn & ~block)) & ~serve;

        // Display shows the current floor whenever no target is active.
        if (disp_load || (req_floor_nxt == NO_REQ)) begin
            sel_nxt = 1'b0;
        end else if (disp_done) begin
            sel_nxt = !sel;
        end

        case (state_nxt)
            ST_MOVE_UP: status_nxt.moving_up = 1'b1;
            ST_MOVE_DN: status_nxt.moving_dn = 1'b1;
            ST_DOOR:    status_nxt.door_open = 1'b1;
            default:    status_nxt           = '0;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cur_floor <= '0;
            req_floor <= NO_REQ;
            req_mask  <= '0;
            sel       <= 1'b0;
            moving_up <= 1'b0;
            moving_dn <= 1'b0;
            door_open <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_floor <= cur_floor_nxt;
            req_floor <= req_floor_nxt;
            req_mask  <= req_mask_nxt;
            sel       <= sel_nxt;
            moving_up <= status_nxt.moving_up;
            moving_dn <= status_nxt.moving_dn;
            door_open <= status_nxt.door_open;
        end
    end

endmodule

// File: tb/tb_elevator_floor_ctrl.sv
// Scoreboard bench for elevator_floor_ctrl with short timer parameters.
// Stimulus pushes the expected output-change timeline (and state snapshots)
// before driving buttons; a negedge monitor pops and compares.
module tb_elevator_floor_ctrl;

    localparam int TRAVEL = 4;
    localparam int DOOR   = 6;
    localparam int DISP   = 2;

    typedef struct packed {
        int         cyc;
        logic [8:0] o;
    } ev_t;

    typedef struct packed {
        int         cyc;
        logic [8:0] o;
        logic [3:0] m;
    } snap_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic [1:0] cur_floor;
    logic [2:0] req_floor;
    logic       sel;
    logic       moving_up;
    logic       moving_dn;
    logic       door_open;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;
    bit    fin_req = 1'b0;
    ev_t   exp_q[$];
    snap_t snap_q[$];
    logic [8:0] tl_prev;
    logic [8:0] mon_prev;
    logic [8:0] now_o;
    ev_t        ev;
    snap_t      sn;

    elevator_floor_ctrl #(
        .TRAVEL_TICKS (TRAVEL),
        .DOOR_TICKS   (DOOR),
        .DISP_TICKS   (DISP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .cur_floor (cur_floor),
        .req_floor (req_floor),
        .sel       (sel),
        .moving_up (moving_up),
        .moving_dn (moving_dn),
        .door_open (door_open)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output tuple: {cur_floor, req_floor, sel, moving_up, moving_dn, door_open}.
    function automatic logic [8:0] mk(input int f, input int r, input int s,
                                      input int u, input int d, input int o);
        return {2'(f), 3'(r), 1'(s), 1'(u), 1'(d), 1'(o)};
    endfunction

    task automatic emit(input int c, input logic [8:0] o);
        if (o !== tl_prev) begin
            exp_q.push_back('{cyc: c, o: o});
            tl_prev = o;
        end
    endtask

    task automatic snap(input int c, input logic [8:0] o, input logic [3:0] m);
        snap_q.push_back('{cyc: c, o: o, m: m});
    endtask

    // Expected timeline of one served request: target loaded at edge l,
    // one floor per TRAVEL cycles, DOOR (+ext) cycles open, then idle at e.
    // A nonzero stop cuts the trip short with a reset taking effect at that edge.
    task automatic trip(input int l, input int s, input int t, input int ext,
                        input int stop, output int e);
        int d, last, f, steps;
        d    = l + TRAVEL * ((s > t) ? s - t : t - s);
        e    = d + DOOR + ext;
        last = (stop > 0) ? stop - 1 : e - 1;
        for (int c = l; c <= last; c++) begin
            steps = (c - l) / TRAVEL;
            if (c >= d)     f = t;
            else if (t > s) f = s + steps;
            else            f = s - steps;
            emit(c, mk(f, t, ((c - l) / DISP) % 2,
                       (c < d && t > s) ? 1 : 0,
                       (c < d && t < s) ? 1 : 0,
                       (c >= d) ? 1 : 0));
        end
        if (stop > 0) emit(stop, mk(0, 7, 0, 0, 0, 0));
        else          emit(e, mk(t, 7, 0, 0, 0, 0));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare every output change and every due snapshot.
    always @(negedge clk) begin
        now_o = {cur_floor, req_floor, sel, moving_up, moving_dn, door_open};
        if (mon_en && (now_o !== mon_prev)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d got=%b", cyc, now_o);
            end else begin
                ev = exp_q.pop_front();
                if ((ev.cyc != cyc) || (ev.o !== now_o)) begin
                    errors++;
                    $display("FAIL out_change got=%b@%0d want=%b@%0d", now_o, cyc, ev.o, ev.cyc);
                end
            end
        end
        mon_prev = now_o;

        if ((snap_q.size() != 0) && (snap_q[0].cyc <= cyc)) begin
            sn = snap_q.pop_front();
            checks++;
            if ((sn.cyc != cyc) || (sn.o !== now_o) || (sn.m !== dut.req_mask)) begin
                errors++;
                $display("FAIL snapshot cyc=%0d got=%b mask=%b want=%b mask=%b@%0d",
                         cyc, now_o, dut.req_mask, sn.o, sn.m, sn.cyc);
            end
        end

        if (fin_req) begin
            while (exp_q.size() != 0) begin
                ev = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_change want=%b@%0d", ev.o, ev.cyc);
            end
            while (snap_q.size() != 0) begin
                sn = snap_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_snapshot want=%b@%0d", sn.o, sn.cyc);
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    initial begin
        int k, l, e, e1, e2;
        tl_prev = mk(0, 7, 0, 0, 0, 0);
        reset   = 1'b1;
        btn     = 4'b0000;

        // Reset, then 50 idle cycles with no output activity.
        step(3);
        reset  = 1'b0;
        mon_en = 1'b1;
        snap(cyc, mk(0, 7, 0, 0, 0, 0), 4'b0000);
        step(50);
        snap(cyc, mk(0, 7, 0, 0, 0, 0), 4'b0000);

        // Floor 0 -> 3 on a single-cycle press.
        k = cyc;
        trip(k + 2, 0, 3, 0, 0, e);
        btn = 4'b1000;
        step(1);
        btn = 4'b0000;
        step(e + 1 - cyc);

        // Two simultaneous calls from floor 3: floor 1 first, then floor 2.
        k = cyc;
        trip(k + 2, 3, 1, 0, 0, e1);
        trip(e1 + 1, 1, 2, 0, 0, e2);
        btn = 4'b0110;
        step(1);
        btn = 4'b0000;
        step(e2 + 1 - cyc);
        snap(cyc, mk(2, 7, 0, 0, 0, 0), 4'b0000);

        // Back down to floor 0.
        k = cyc;
        trip(k + 2, 2, 0, 0, 0, e);
        btn = 4'b0001;
        step(1);
        btn = 4'b0000;
        step(e + 1 - cyc);

        // Call at the current floor: door opens directly; re-press extends it.
        k = cyc;
        l = k + 2;
        trip(l, 0, 0, 3, 0, e);
        btn = 4'b0001;
        step(1);
        btn = 4'b0000;
        step(l + 2 - cyc);
        btn = 4'b0001;
        step(1);
        btn = 4'b0000;
        step(e + 1 - cyc);
        snap(cyc, mk(0, 7, 0, 0, 0, 0), 4'b0000);

        // Reset while travelling up past floor 2, with a call held during reset.
        k = cyc;
        l = k + 2;
        trip(l, 0, 3, 0, l + 10, e);
        btn = 4'b1000;
        step(1);
        btn = 4'b0000;
        step(l + 9 - cyc);
        reset = 1'b1;
        btn   = 4'b0010;
        snap(l + 10, mk(0, 7, 0, 0, 0, 0), 4'b0000);
        step(2);
        reset = 1'b0;
        btn   = 4'b0000;
        step(20);
        snap(cyc, mk(0, 7, 0, 0, 0, 0), 4'b0000);

        step(2);
        fin_req = 1'b1;
        step(3);
        $display("FAIL monitor_did_not_finish cyc=%0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/elevator_floor_ctrl.md
ELEVATOR_FLOOR_CTRL -- requirements
Module: elevator_floor_ctrl

Interface
REQ-001 Parameter TRAVEL_TICKS, default 50_000_000; clock cycles spent travelling between adjacent floors.
REQ-002 Parameter DOOR_TICKS, default 100_000_000; clock cycles the door is held open.
REQ-003 Parameter DISP_TICKS, default 25_000_000; clock cycles per display-alternation phase.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 btn  input  4  floor-call buttons, bit i = floor i (0..3), level-sensitive, already synchronised.
REQ-007 cur_floor  output  2  current cabin floor code; feeds the display mux "current" inputs.
REQ-008 req_floor  output  3  active target floor 0..3, or 3'b111 when none; feeds the display mux "requested" inputs.
REQ-009 sel  output  1  display-mux select; 0 = show current floor, 1 = show requested floor.
REQ-010 moving_up, moving_dn, door_open  output  1 each  one-hot status flags; all 0 in IDLE.

Function
REQ-011 Request mask req_mask[3:0] SHALL set bit i on the cycle after btn[i]=1, and hold it until floor i is served.
REQ-012 FSM states SHALL be IDLE, MOVE_UP, MOVE_DN, DOOR.
REQ-013 IDLE with req_mask != 0: target SHALL be the lowest set index; next state is MOVE_UP if target > cur_floor, MOVE_DN if lower, DOOR if equal.
REQ-014 Target SHALL stay fixed until DOOR is entered; new presses only set mask bits.
REQ-015 In MOVE_*, the travel counter SHALL count TRAVEL_TICKS cycles, then step cur_floor by ±1 and reload to 0.
REQ-016 When the step makes cur_floor == target, next state SHALL be DOOR, and req_mask[target] SHALL be cleared on that same edge.
REQ-017 DOOR SHALL last exactly DOOR_TICKS cycles, then go to IDLE, with req_floor = 3'b111.
REQ-018 btn[cur_floor] pressed during DOOR SHALL restart the door counter; its mask bit SHALL NOT be set.
REQ-019 cur_floor SHALL never leave 0..3; the stepping logic SHALL NOT wrap.
REQ-020 sel SHALL be 0 whenever req_floor = 3'b111.
REQ-021 Otherwise sel SHALL toggle every DISP_TICKS cycles, starting at 0 on target load.
REQ-022 Simultaneous presses SHALL all be latched; service order SHALL be ascending index per IDLE decision.
REQ-023 Counters SHALL be sized $clog2 of their parameter; no output SHALL depend combinationally on btn.

Reset
REQ-024 Reset SHALL override all other activity, including mid-travel and door-open.
REQ-025 On reset: state=IDLE, cur_floor=0, req_floor=3'b111, req_mask=0, sel=0, all flags 0, all counters 0.
REQ-026 btn asserted during reset SHALL be ignored; latching SHALL resume on the first cycle after reset deasserts.

Structure
REQ-027 The FSM state encoding, the NO_REQ constant (3'b111) and the floor count (4) SHALL live in shared package elevator_pkg.
REQ-028 One sub-module tick_counter (parameter N, inputs clk/reset/clear/en, output done) SHALL implement the travel, door and display timers.

Verification (TRAVEL_TICKS=4, DOOR_TICKS=6, DISP_TICKS=2)
REQ-029 Reset release, no btn -> cur_floor=0, req_floor=7, sel=0, state IDLE held for 50 cycles.
REQ-030 btn=4'b1000 for 1 cycle from floor 0 -> moving_up; cur_floor steps 1,2,3 every 4 cycles; door_open for 6 cycles; then IDLE with req_floor=7.
REQ-031 btn=4'b0110 in one cycle at floor 3 -> floor 1 served first, then floor 2; mask fully cleared at end.
REQ-032 btn[0] pressed at floor 0 while idle -> DOOR entered directly with no movement; pressed again mid-door -> door extended to 6 cycles from the re-press.
REQ-033 Reset asserted mid-MOVE_UP (cur_floor=2) -> next cycle cur_floor=0, all flags 0, req_mask=0.
REQ-034 While a target is pending -> sel pattern 0,0,1,1,0,0…; sel forced to 0 in the cycle req_floor becomes 7.
